// File: rtl/des_sweep_controller.sv
// Sweeps the DES block across an inclusive range of regions, capturing each
// region's ones-count and accumulating a 64-bit total.
module des_sweep_controller #(
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        go_i,
    input  logic        abort_i,
    input  logic [15:0] first_region_i,
    input  logic [15:0] last_region_i,
    input  logic [47:0] blk_counter_i,
    input  logic        blk_valid_i,
    output logic        blk_start_o,
    output logic [15:0] blk_region_select_o,
    output logic [63:0] total_o,
    output logic        rgn_valid_o,
    output logic [15:0] rgn_index_o,
    output logic [47:0] rgn_count_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        cfg_err_o,
    output logic        aborted_o,
    output logic [1:0]  dbg_state_o
);

    // Debug encoding: 0 IDLE, 1 LAUNCH, 2 GAP, 3 DONE.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LAUNCH = 2'd1, S_GAP = 2'd2, S_DONE = 2'd3} state_e;

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] cur_q, cur_d;
    logic [15:0] last_q, last_d;
    logic [15:0] sel_q, sel_d;
    logic        start_q, start_d;
    logic [63:0] total_q, total_d;
    logic        rgn_valid_q, rgn_valid_d;
    logic [15:0] rgn_index_q, rgn_index_d;
    logic [47:0] rgn_count_q, rgn_count_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        cfg_err_q, cfg_err_d;
    logic        aborted_q, aborted_d;
    logic [3:0]  gap_q, gap_d;

    logic accept;
    logic gap_end;
    assign accept  = (last_region_i >= first_region_i);
    assign gap_end = (gap_q == GAP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: if (go_i && accept) state_d = S_LAUNCH;
            S_LAUNCH:       if (abort_i || blk_valid_i) state_d = S_GAP;
            S_GAP: begin
                if (gap_end) begin
                    // Equality before increment: last_region = 16'hFFFF never wraps.
                    if (aborted_q || abort_i)  state_d = S_IDLE;
                    else if (cur_q == last_q)  state_d = S_DONE;
                    else                       state_d = S_LAUNCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cur_d       = cur_q;
        last_d      = last_q;
        sel_d       = sel_q;
        start_d     = start_q;
        total_d     = total_q;
        rgn_valid_d = 1'b0;
        rgn_index_d = rgn_index_q;
        rgn_count_d = rgn_count_q;
        cfg_err_d   = 1'b0;
        aborted_d   = aborted_q;
        gap_d       = gap_q;
        busy_d      = (state_d == S_LAUNCH) || (state_d == S_GAP);
        done_d      = (state_d == S_DONE);
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (go_i) begin
                    if (accept) begin
                        cur_d     = first_region_i;
                        last_d    = last_region_i;
                        sel_d     = first_region_i;
                        start_d   = 1'b1;
                        total_d   = 64'd0;
                        aborted_d = 1'b0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_LAUNCH: begin
                // Abort wins over a simultaneous result: the region is dropped.
                if (abort_i) begin
                    start_d   = 1'b0;
                    aborted_d = 1'b1;
                    gap_d     = 4'd0;
                end else if (blk_valid_i) begin
                    start_d     = 1'b0;
                    total_d     = total_q + 64'(blk_counter_i);
                    rgn_count_d = blk_counter_i;
                    rgn_index_d = cur_q;
                    rgn_valid_d = 1'b1;
                    gap_d       = 4'd0;
                end
            end
            S_GAP: begin
                if (abort_i) aborted_d = 1'b1;
                gap_d = gap_q + 4'd1;
                if (state_d == S_LAUNCH) begin
                    cur_d   = cur_q + 16'd1;
                    sel_d   = cur_q + 16'd1;
                    start_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q       <= '0;
            last_q      <= '0;
            sel_q       <= '0;
            start_q     <= 1'b0;
            total_q     <= '0;
            rgn_valid_q <= 1'b0;
            rgn_index_q <= '0;
            rgn_count_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            aborted_q   <= 1'b0;
            gap_q       <= '0;
        end else begin
            cur_q       <= cur_d;
            last_q      <= last_d;
            sel_q       <= sel_d;
            start_q     <= start_d;
            total_q     <= total_d;
            rgn_valid_q <= rgn_valid_d;
            rgn_index_q <= rgn_index_d;
            rgn_count_q <= rgn_count_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
            aborted_q   <= aborted_d;
            gap_q       <= gap_d;
        end
    end

    assign blk_start_o         = start_q;
    assign blk_region_select_o = sel_q;
    assign total_o             = total_q;
    assign rgn_valid_o         = rgn_valid_q;
    assign rgn_index_o         = rgn_index_q;
    assign rgn_count_o         = rgn_count_q;
    assign busy_o              = busy_q;
    assign done_o              = done_q;
    assign cfg_err_o           = cfg_err_q;
    assign aborted_o           = aborted_q;
    assign dbg_state_o         = state_q;

endmodule

// File: tb/tb_des_sweep_controller.sv
// Bench for des_sweep_controller: a reactive DES block model, a sweep reference
// model feeding an expected queue, and a monitor that checks every rgn_valid.
module tb_des_sweep_controller;
  localparam int G = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        go, abort;
  logic [15:0] first_region, last_region;
  logic [47:0] blk_counter;
  logic        blk_valid;
  logic        blk_start;
  logic [15:0] blk_region_select;
  logic [63:0] total;
  logic        rgn_valid;
  logic [15:0] rgn_index;
  logic [47:0] rgn_count;
  logic        busy, done, cfg_err, aborted;
  logic [1:0]  dbg_state;

  des_sweep_controller #(.GAP_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .go_i(go), .abort_i(abort),
    .first_region_i(first_region), .last_region_i(last_region),
    .blk_counter_i(blk_counter), .blk_valid_i(blk_valid),
    .blk_start_o(blk_start), .blk_region_select_o(blk_region_select),
    .total_o(total), .rgn_valid_o(rgn_valid), .rgn_index_o(rgn_index),
    .rgn_count_o(rgn_count), .busy_o(busy), .done_o(done),
    .cfg_err_o(cfg_err), .aborted_o(aborted), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cfg_err_seen = 0;
  logic [127:0] exp_q[$];        // {index16, count48, running_total64}
  logic [47:0]  tbl[int];        // per-region ones-count the block model returns
  bit lat_zero = 0;
  bit hold_off = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // DES block: raises valid after a random latency while start is high,
  // and sometimes lets valid linger one cycle after start drops.
  initial begin : blk_model
    int wait_cnt;
    int lat;
    bit lingered;
    wait_cnt = 0; lat = 0; lingered = 0;
    blk_valid = 1'b0; blk_counter = '0;
    forever begin
      @(posedge clk); #1;
      if (!blk_start) begin
        if (blk_valid && !lingered && $urandom_range(0, 1) == 1) lingered = 1;
        else begin blk_valid = 1'b0; lingered = 0; end
        wait_cnt = 0;
        lat = lat_zero ? 0 : $urandom_range(0, 3);
      end else if (!blk_valid && !hold_off) begin
        if (wait_cnt >= lat) begin
          blk_valid = 1'b1;
          blk_counter = tbl.exists(int'(blk_region_select)) ? tbl[int'(blk_region_select)] : 48'h0;
        end else wait_cnt++;
      end
    end
  end

  // Monitor: result pulses, cfg_err pulses, gap length, select stability.
  initial begin : monitor
    logic [127:0] e;
    int low_cnt;
    bit prev_start;
    logic [15:0] prev_sel;
    low_cnt = 0; prev_start = 0; prev_sel = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        low_cnt = 0; prev_start = 0;
      end else begin
        if (rgn_valid) begin
          if (exp_q.size() == 0) check("unexpected_rgn_valid", 64'd1, 64'd0);
          else begin
            e = exp_q.pop_front();
            check("rgn_index", 64'(rgn_index), 64'(e[127:112]));
            check("rgn_count", 64'(rgn_count), 64'(e[111:64]));
            check("rgn_total", total, e[63:0]);
          end
        end
        if (cfg_err) cfg_err_seen++;
        if (busy && !blk_start) low_cnt++;
        else if (blk_start && low_cnt != 0) begin
          check("gap_len", 64'(low_cnt), 64'(G));
          low_cnt = 0;
        end else if (!busy) low_cnt = 0;
        if (blk_start && prev_start) check("sel_stable", 64'(blk_region_select), 64'(prev_sel));
        prev_start = blk_start;
        prev_sel = blk_region_select;
      end
    end
  end

  task automatic fill(input int f, input int l);
    for (int r = f; r <= l; r++) tbl[r] = {16'($urandom), 32'($urandom)};
  endtask

  // Reference: regions f..l in order, stopping before stop_at; running sum.
  task automatic model_sweep(input int f, input int l, input int stop_at, output logic [63:0] t);
    t = 64'd0;
    for (int r = f; r <= l && r < stop_at; r++) begin
      t = t + 64'(tbl[r]);
      exp_q.push_back({16'(r), tbl[r], t});
    end
  endtask

  task automatic pulse_go(input int f, input int l);
    @(posedge clk); #1;
    go = 1'b1; first_region = 16'(f); last_region = 16'(l);
    @(posedge clk); #1;
    go = 1'b0; first_region = 16'($urandom); last_region = 16'($urandom);
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    while (busy && k < bound) begin @(negedge clk); k++; end
    check("sweep_timeout", 64'(busy), 64'd0);
  endtask

  task automatic finish_sweep(input logic [63:0] t);
    wait_idle(2000);
    check("done", 64'(done), 64'd1);
    check("final_total", total, t);
    check("aborted_clear", 64'(aborted), 64'd0);
    check("start_low_done", 64'(blk_start), 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_sweep(input int f, input int l);
    logic [63:0] t;
    model_sweep(f, l, 1 << 20, t);
    pulse_go(f, l);
    check("start_after_go", 64'(blk_start), 64'd1);
    check("sel_after_go", 64'(blk_region_select), 64'(f));
    finish_sweep(t);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #2000000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [63:0] t;
    logic [63:0] saved_total;
    int c0, k, f, len;
    bit found;
    rst_n = 1'b0; go = 1'b0; abort = 1'b0; first_region = '0; last_region = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_blk_start", 64'(blk_start), 64'd0);
    check("rst_sel", 64'(blk_region_select), 64'd0);
    check("rst_total", total, 64'd0);
    check("rst_rgn_valid", 64'(rgn_valid), 64'd0);
    check("rst_rgn_index", 64'(rgn_index), 64'd0);
    check("rst_rgn_count", 64'(rgn_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_cfg_err", 64'(cfg_err), 64'd0);
    check("rst_aborted", 64'(aborted), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Three regions with known counts.
    tbl[5] = 48'd10; tbl[6] = 48'd20; tbl[7] = 48'd30;
    run_sweep(5, 7);
    check("sum_5_7", total, 64'd60);

    // Top region only, maximum count; must not wrap to region 0.
    tbl[65535] = 48'hFFFF_FFFF_FFFF;
    tbl[0] = 48'h1;
    run_sweep(65535, 65535);
    check("max_total", total, 64'h0000_FFFF_FFFF_FFFF);
    repeat (10) @(negedge clk);
    check("no_wrap_start", 64'(blk_start), 64'd0);
    check("no_wrap_done", 64'(done), 64'd1);

    // Rejected go from DONE leaves everything alone.
    c0 = cfg_err_seen; saved_total = total;
    pulse_go(9, 3);
    repeat (3) @(negedge clk);
    check("cfg_err_once_done", 64'(cfg_err_seen), 64'(c0 + 1));
    check("reject_start", 64'(blk_start), 64'd0);
    check("reject_done_kept", 64'(done), 64'd1);
    check("reject_total_kept", total, saved_total);
    check("reject_state_done", 64'(dbg_state), 64'd3);

    // Rejected go from IDLE.
    do_reset();
    c0 = cfg_err_seen;
    pulse_go(9, 3);
    repeat (3) @(negedge clk);
    check("cfg_err_once_idle", 64'(cfg_err_seen), 64'(c0 + 1));
    check("reject_idle_start", 64'(blk_start), 64'd0);
    check("reject_state_idle", 64'(dbg_state), 64'd0);

    // Abort coincident with blk_valid in region 2 of 0..4.
    fill(0, 4);
    lat_zero = 1;
    model_sweep(0, 4, 2, t);
    pulse_go(0, 4);
    k = 0; found = 0;
    while (!found && k < 500) begin
      @(negedge clk); k++;
      found = blk_start && (blk_region_select == 16'd2);
    end
    check("abort_region_reached", 64'(found), 64'd1);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    repeat (G - 1) @(posedge clk);
    @(negedge clk);
    check("abort_gap_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("abort_idle_busy", 64'(busy), 64'd0);
    check("abort_state", 64'(dbg_state), 64'd0);
    check("abort_flag", 64'(aborted), 64'd1);
    check("abort_done", 64'(done), 64'd0);
    check("abort_total", total, t);
    check("abort_queue", 64'(exp_q.size()), 64'd0);
    lat_zero = 0;

    // Asynchronous reset in the middle of a LAUNCH.
    fill(0, 3);
    model_sweep(0, 3, 1 << 20, t);
    pulse_go(0, 3);
    k = 0;
    while (!(busy && !blk_start) && k < 500) begin @(negedge clk); k++; end
    hold_off = 1;
    k = 0;
    while (!(blk_start && blk_region_select == 16'd1) && k < 500) begin @(negedge clk); k++; end
    check("midlaunch_reached", 64'(blk_region_select), 64'd1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_start", 64'(blk_start), 64'd0);
    check("async_rst_total", total, 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    hold_off = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_idle", 64'(dbg_state), 64'd0);
    check("post_rst_start", 64'(blk_start), 64'd0);
    fill(2, 4);
    run_sweep(2, 4);

    // go during a running sweep is ignored.
    fill(10, 12);
    model_sweep(10, 12, 1 << 20, t);
    pulse_go(10, 12);
    @(negedge clk);
    go = 1'b1; first_region = 16'd0; last_region = 16'd100;
    @(negedge clk);
    go = 1'b0;
    finish_sweep(t);

    // Randomized sweeps, including one ending at the top region.
    fill(65533, 65535);
    run_sweep(65533, 65535);
    for (int i = 0; i < 6; i++) begin
      f = $urandom_range(0, 65530);
      len = $urandom_range(0, 4);
      fill(f, f + len);
      run_sweep(f, f + len);
    end

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/des_sweep_controller.md
DES_SWEEP_CONTROLLER -- requirements
Module: des_sweep_controller

Interface
REQ-001 Parameter GAP_CYCLES, default 2, number of cycles blk_start is held low between regions; legal values 2-15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active low.
REQ-004 go  input  1  single-cycle sweep request; sampled only in IDLE/DONE.
REQ-005 abort  input  1  terminate the sweep early; sampled in LAUNCH/GAP.
REQ-006 first_region  input  16  first region_select value of the sweep; sampled on accepted go.
REQ-007 last_region  input  16  last region_select value, inclusive; sampled on accepted go.
REQ-008 blk_counter  input  48  ones-count result from the DES block.
REQ-009 blk_valid  input  1  DES block result-valid, level; held while blk_start is high.
REQ-010 blk_start  output  1  registered start/run level to the DES block.
REQ-011 blk_region_select  output  16  registered region index to the DES block.
REQ-012 total  output  64  running sum of all captured blk_counter values.
REQ-013 rgn_valid  output  1  one-cycle pulse; rgn_index/rgn_count hold a new per-region result.
REQ-014 rgn_index  output  16  region of the last captured result.
REQ-015 rgn_count  output  48  blk_counter value of the last captured result.
REQ-016 busy  output  1  high in LAUNCH and GAP.
REQ-017 done  output  1  high in DONE; held until the next accepted go.
REQ-018 cfg_err  output  1  one-cycle pulse on a rejected go.
REQ-019 aborted  output  1  sticky flag set by abort; cleared on the next accepted go.

Function
REQ-020 States: IDLE, LAUNCH, GAP, DONE; all outputs are registered.
REQ-021 IDLE/DONE, go=1, last_region>=first_region: accept; cur<=first_region, blk_region_select<=first_region, blk_start<=1, total<=0, done<=0, aborted<=0, go to LAUNCH; blk_start is high the cycle after go.
REQ-022 IDLE/DONE, go=1, last_region<first_region: reject; cfg_err pulses one cycle; state and all other outputs unchanged.
REQ-023 go in LAUNCH or GAP is ignored.
REQ-024 LAUNCH, blk_valid=1, abort=0: on that edge blk_start<=0, total<=total+blk_counter, rgn_count<=blk_counter, rgn_index<=cur, rgn_valid<=1, gap counter<=0, go to GAP.
REQ-025 Capture happens exactly once per region; blk_valid seen in GAP, IDLE or DONE is ignored.
REQ-026 GAP holds blk_start low for exactly GAP_CYCLES cycles; blk_region_select updates only in GAP, never while blk_start is high.
REQ-027 GAP end, cur==last_region: go to DONE, done<=1, blk_start stays 0.
REQ-028 GAP end, cur!=last_region: cur<=cur+1, blk_region_select<=cur+1, blk_start<=1, go to LAUNCH.
REQ-029 The last-region check is equality before increment; last_region=16'hFFFF terminates with no wrap to 0.
REQ-030 total is 64-bit unsigned with no saturation; 65536 x (2^48-1) cannot overflow.
REQ-031 abort=1 in LAUNCH: blk_start<=0, aborted<=1, no capture, even if blk_valid=1 on the same cycle; go to GAP.
REQ-032 GAP end with aborted=1: go to IDLE; done stays 0; total keeps the partial sum.
REQ-033 LAUNCH has no timeout; it waits on blk_valid indefinitely.

Reset
REQ-034 rst_n low at any time, asynchronously: state=IDLE; blk_start=0, blk_region_select=0, total=0, rgn_valid=0, rgn_index=0, rgn_count=0, busy=0, done=0, cfg_err=0, aborted=0, cur=0, gap counter=0.
REQ-035 After rst_n is released mid-sweep, the block stays in IDLE and no capture happens until a new go.

Verification
REQ-036 first=5, last=7, model returns 10,20,30 -> rgn_valid three times with index 5,6,7; total=60; done=1; blk_start low exactly 2 cycles between regions.
REQ-037 first=last=16'hFFFF, counter=48'hFFFF_FFFF_FFFF -> one region; total=64'h0000_FFFF_FFFF_FFFF; done=1; no second launch at region 0.
REQ-038 first=9, last=3 -> cfg_err pulses once; blk_start stays 0; state stays IDLE.
REQ-039 abort and blk_valid on the same cycle in region 2 of 0..4 -> no capture for region 2; aborted=1; done=0; return to IDLE after GAP_CYCLES.
REQ-040 rst_n asserted mid-LAUNCH -> blk_start=0 and total=0 immediately, without a clock edge; new go restarts cleanly.
REQ-041 go pulsed during LAUNCH -> ignored; first_region is not resampled; sweep result unchanged.
